// File: rtl/dds_tone_mixer_if.sv
// Avalon-MM register port of the DDS tone mixer: word address, 1-cycle read latency, no waitrequest.
interface dds_tone_mixer_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/dds_tone_mixer.sv
// Multi-channel DDS tone mixer: time-multiplexed phase accumulators sharing one quarter-wave
// sine LUT and one multiplier, saturating sum, offset-binary sample at a programmable rate.
module dds_tone_mixer #(
  parameter int CHANNELS   = 4,
  parameter int PHASE_W    = 24,
  parameter int LUT_ADDR_W = 6,
  parameter int OUT_W      = 7,
  parameter int SAMPLE_DIV = 64
) (
  input  logic              clk,
  input  logic              reset,
  dds_tone_mixer_if.slave   avs,
  output logic [OUT_W-1:0]  sample_out,
  output logic              sample_valid
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SUM_W = OUT_W + $clog2(CHANNELS) + 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int LUT_N = 2**LUT_ADDR_W;
  localparam int MAG   = 2**(OUT_W-1) - 1;
  localparam longint PI_FX = 64'sd843314857;  // pi * 2^28

  localparam logic [OUT_W-1:0]        MID  = OUT_W'(MAG + 1);
  localparam logic signed [SUM_W-1:0] SMAX = SUM_W'(MAG);
  localparam logic signed [SUM_W-1:0] SMIN = -SUM_W'(MAG);

  // Elaboration-time sine in 2^28 fixed point (Taylor series), rounded to the output scale.
  function automatic int lut_val(input int unsigned idx);
    longint x, x2, term, acc;
    x    = (PI_FX * longint'(2*idx + 1)) / (longint'(4) << LUT_ADDR_W);
    x2   = (x * x) >>> 28;
    term = x;
    acc  = x;
    for (int unsigned n = 1; n <= 8; n++) begin
      term = -((term * x2) >>> 28) / longint'((2*n) * (2*n + 1));
      acc  = acc + term;
    end
    return int'((longint'(MAG) * acc + (longint'(1) <<< 27)) >>> 28);
  endfunction

  logic [LUT_N-1:0][OUT_W-2:0] lut;
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam int V = lut_val(g);
    assign lut[g] = V[OUT_W-2:0];
  end

  typedef enum logic [2:0] {IDLE, FETCH, MUL, ACC, OUT} state_t;
  state_t state, state_next;

  logic                     en, clip;
  logic [PHASE_W-1:0]       pinc  [CHANNELS];
  logic [PHASE_W-1:0]       phase [CHANNELS];
  logic [7:0]               amp   [CHANNELS];
  logic [CHANNELS-1:0]      cen;
  logic [DIV_W-1:0]         div;
  logic [CH_W-1:0]          ch;
  logic signed [SUM_W-1:0]  sum;
  logic signed [OUT_W-1:0]  s_reg;
  logic [7:0]               amp_reg;
  logic signed [OUT_W:0]    p_reg;

  logic                     wr_ctrl, wr_stat, en_new, prst, abort, tick, busy, last;
  logic [PHASE_W-1:0]       cur_phase;
  logic [1:0]               quad;
  logic [LUT_ADDR_W-1:0]    lidx;
  logic signed [OUT_W-1:0]  s_fetch;
  logic signed [OUT_W+8:0]  prod;
  logic signed [SUM_W-1:0]  p_ext, sat;
  logic                     clip_hit;
  logic [31:0]              rd_mux;
  logic                     unused_wdata;

  assign unused_wdata = ^avs.avs_writedata;

  assign wr_ctrl = avs.avs_write && (avs.avs_address == 5'd0);
  assign wr_stat = avs.avs_write && (avs.avs_address == 5'd1);
  assign en_new  = wr_ctrl ? avs.avs_writedata[0] : en;
  assign prst    = wr_ctrl && avs.avs_writedata[1];
  assign abort   = prst || !en_new;
  assign tick    = en && (div == DIV_W'(SAMPLE_DIV - 1));
  assign busy    = (state != IDLE);
  assign last    = (ch == CH_W'(CHANNELS - 1));

  // Quarter-wave folding: odd quadrants mirror the index, upper half negates.
  assign cur_phase = phase[ch];
  assign quad      = cur_phase[PHASE_W-1 -: 2];
  assign lidx      = quad[0] ? ~cur_phase[PHASE_W-3 -: LUT_ADDR_W]
                             :  cur_phase[PHASE_W-3 -: LUT_ADDR_W];
  assign s_fetch   = quad[1] ? -$signed({1'b0, lut[lidx]}) : $signed({1'b0, lut[lidx]});

  assign prod  = s_reg * $signed({1'b0, amp_reg});
  assign p_ext = SUM_W'(p_reg);

  always_comb begin
    sat      = sum;
    clip_hit = 1'b0;
    if (sum > SMAX) begin
      sat      = SMAX;
      clip_hit = 1'b1;
    end else if (sum < SMIN) begin
      sat      = SMIN;
      clip_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = FETCH;
      FETCH:   state_next = MUL;
      MUL:     state_next = ACC;
      ACC:     state_next = last ? OUT : FETCH;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en           <= 1'b0;
      clip         <= 1'b0;
      cen          <= '0;
      div          <= '0;
      ch           <= '0;
      sum          <= '0;
      s_reg        <= '0;
      amp_reg      <= '0;
      p_reg        <= '0;
      sample_out   <= MID;
      sample_valid <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        pinc[k]  <= '0;
        phase[k] <= '0;
        amp[k]   <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      if (!en_new) sample_out <= MID;

      if (wr_ctrl) en <= avs.avs_writedata[0];
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (avs.avs_write && avs.avs_address == 5'(2 + 2*k))
          pinc[k] <= avs.avs_writedata[PHASE_W-1:0];
        if (avs.avs_write && avs.avs_address == 5'(3 + 2*k)) begin
          cen[k] <= avs.avs_writedata[0];
          amp[k] <= avs.avs_writedata[15:8];
        end
      end

      if (state == OUT && !abort && clip_hit) clip <= 1'b1;
      else if (wr_stat && avs.avs_writedata[1]) clip <= 1'b0;

      // Restart counts the write cycle itself as 0, so the first tick lands SAMPLE_DIV-1 later.
      if (!en_new)   div <= '0;
      else if (prst) div <= DIV_W'(1);
      else if (tick) div <= '0;
      else           div <= div + DIV_W'(1);

      if (prst) begin
        for (int unsigned k = 0; k < CHANNELS; k++) phase[k] <= '0;
      end else if (!abort) begin
        case (state)
          IDLE: if (tick) begin
            ch  <= '0;
            sum <= '0;
          end
          FETCH: begin
            s_reg   <= s_fetch;
            amp_reg <= amp[ch];
          end
          MUL: p_reg <= $signed(prod[OUT_W+8:8]);
          ACC: begin
            if (cen[ch]) begin
              sum       <= sum + p_ext;
              phase[ch] <= phase[ch] + pinc[ch];
            end
            if (!last) ch <= ch + CH_W'(1);
          end
          OUT: begin
            sample_out   <= sat[OUT_W-1:0] + MID;
            sample_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (avs.avs_address == 5'd0) rd_mux[0] = en;
    if (avs.avs_address == 5'd1) rd_mux[1:0] = {clip, busy};
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (avs.avs_address == 5'(2 + 2*k)) rd_mux = 32'(pinc[k]);
      if (avs.avs_address == 5'(3 + 2*k)) rd_mux = {16'd0, amp[k], 7'd0, cen[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             avs.avs_readdata <= '0;
    else if (avs.avs_read) avs.avs_readdata <= rd_mux;
  end

endmodule

// File: doc/dds_tone_mixer.md
# dds_tone_mixer

Multi-channel direct-digital-synthesis tone generator with an Avalon-MM register slave, the parametrised successor to the single fixed 7-bit sine output on the Platform Designer system. It runs CHANNELS phase accumulators through one shared quarter-wave sine LUT and one shared multiplier. Each channel has its own amplitude. The channels are summed with saturation into an offset-binary sample at a programmable sample rate, and that sample drives the audio/DAC conduit.

## Interface
- CHANNELS, 4, number of tone channels (1..15)
- PHASE_W, 24, phase accumulator width (≤32)
- LUT_ADDR_W, 6, quarter-wave LUT address bits (2^LUT_ADDR_W entries)
- OUT_W, 7, output sample width
- SAMPLE_DIV, 64, clocks per sample period; must be ≥ 3*CHANNELS+3
- clk in 1: the single clock; all logic is on its rising edge
- reset in 1: synchronous, active-high
- avs_address in 5: word address
- avs_read in 1: read strobe
- avs_write in 1: write strobe
- avs_writedata in 32: write data
- avs_readdata out 32: read data, fixed latency of 1 cycle, no waitrequest
- sample_out out OUT_W: offset-binary mixed sample
- sample_valid out 1: one-cycle pulse when sample_out updates

## Operation
- Register map:
  - 0 CTRL: bit0 EN (global enable); bit1 PRST, write-1 pulse that self-clears and reads as 0.
  - 1 STATUS: bit0 BUSY (read-only); bit1 CLIP (sticky, write-1-to-clear).
  - 2+2k PINC_k: bits[PHASE_W-1:0].
  - 3+2k CHCFG_k: bit0 CEN; bits[15:8] AMP, unsigned, where 255 ≈ 1.0.
  - Unmapped addresses read 0 and ignore writes.
  - Unused bits read 0.
- Reads and writes:
  - If a read and a write hit the same address in the same cycle, the read returns the old value.
  - A CLIP set and a CLIP clear in the same cycle: the set wins.
- Divider:
  - Counts 0..SAMPLE_DIV-1 while EN=1.
  - "Tick" is the cycle in which the count is SAMPLE_DIV-1.
  - When EN=0 the divider is held at 0.
- FSM states: IDLE, FETCH, MUL, ACC, OUT.
  - IDLE→FETCH on a tick, with channel index 0 and the sum cleared.
  - FETCH: the phase top bits form the LUT address.
    - Quadrant q = phase[PHASE_W-1:PHASE_W-2].
    - Index i = the next LUT_ADDR_W bits.
    - When q is odd the index is mirrored: i' = ~i.
    - The value is negated when q ≥ 2.
    - LUT[i] = round((2^(OUT_W-1)-1)·sin(π/2·(i+0.5)/2^LUT_ADDR_W)).
  - MUL: p = (s·AMP) >>> 8, an arithmetic shift (floor).
  - ACC:
    - If CEN=1, the sum gains p and phase_k += PINC_k (mod 2^PHASE_W).
    - If CEN=0, the channel contributes 0 and its phase is held.
    - Then the next channel goes to FETCH; after the last channel the FSM goes to OUT.
  - OUT → IDLE:
    - The sum is saturated to ±(2^(OUT_W-1)-1).
    - If saturation occurred, CLIP is set.
    - sample_out = saturated sum + 2^(OUT_W-1).
    - sample_valid pulses.
- The sum register is OUT_W+clog2(CHANNELS)+1 bits signed; it can never overflow.
- PINC and CHCFG writes take effect immediately. A channel uses the register value present in its own FETCH/ACC cycles.
- PRST:
  - Zeroes all accumulators, aborts any sequence in progress with the FSM going to IDLE and no sample_valid for that frame, and restarts the divider at 0.
- EN cleared (1→0):
  - Aborts the sequence.
  - sample_out goes to midscale on the next cycle.
  - sample_valid stays 0.
  - Phases are held.
- BUSY=1 in any state other than IDLE.

## Timing
- Reset values:
  - sample_out = 2^(OUT_W-1), which is 64 for OUT_W=7.
  - sample_valid = 0.
  - avs_readdata = 0.
  - All registers, accumulators and the divider are 0.
  - FSM = IDLE.
- With the tick in cycle T:
  - FSM is in FETCH for channel 0 in cycle T+1.
  - Channel k occupies cycles T+1+3k through T+3+3k.
  - OUT is in cycle T+3·CHANNELS+1.
  - sample_out and sample_valid are visible in cycle T+3·CHANNELS+2.
- The first tick comes SAMPLE_DIV-1 cycles after the cycle in which EN is written to 1.
- The sample period is exactly SAMPLE_DIV cycles. The sequence always completes before the next tick.
- avs_readdata is valid in the cycle after avs_read and holds until the next read.

## Test plan
All scenarios use CHANNELS=4, PHASE_W=24, LUT_ADDR_W=6, OUT_W=7, SAMPLE_DIV=64.
- Reset → sample_out=64, sample_valid=0, every register reads 0, BUSY=0, and no valid pulses appear with EN=0.
- Single tone:
  - Stimulus: PINC_0=0x400000, CHCFG_0=0xFF01, EN=1.
  - Response: successive samples are 64, 126, 63, 1, 64, …
  - sample_valid pulses come 64 cycles apart, and the first arrives 63+14 cycles after the EN write.
- Saturation:
  - Stimulus: all four channels set to PINC=0x400000 and AMP=255 with CEN=1; PRST then EN.
  - Response: the second sample is 127 (sum 248 saturated to 63), and STATUS.CLIP=1.
  - Writing STATUS=0x2 clears CLIP.
- PRST in the middle of a sequence (cycle T+5):
  - Response: no sample_valid that frame, BUSY drops the next cycle, the next valid comes 63+14 cycles later, and its value equals the phase-0 sample (64 for the single-tone setup).
- Disabled channel and global disable:
  - With CEN_0 cleared for 3 samples then re-set, the channel resumes at the held phase; the sequence continues from where it stopped.
  - Clearing EN during a sequence gives sample_out=64 the next cycle and no further sample_valid.
- Register readback:
  - PINC_0 written with 0xFFFFFFFF reads 0x00FFFFFF.
  - CHCFG_1 written with 0xFFFFFFFF reads 0x0000FF01.
  - Address 31 reads 0.
  - Readdata appears exactly 1 cycle after avs_read.
  - A same-cycle read and write to the same address returns the old value.
